exc_ctrl: RTL

//  Exception/interrupt sequencer between the MEM stage and the CP0 register file.

---
 rtl/exc_if.sv | 45 ++++
 rtl/exc_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/exc_if.sv
// Bundle between the MEM stage / CP0 file and the exception sequencer.
// slave = sequencer side, master = pipeline/CP0 side driving the requests.
interface exc_if;
  logic        mem_valid_i;
  logic        stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_bad_addr_i;
  logic        adel_if_i;
  logic        ri_i;
  logic        ov_i;
  logic        trap_i;
  logic        syscall_i;
  logic        break_i;
  logic        adel_ld_i;
  logic        ades_i;
  logic        eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] newpc_o;
  logic        busy_o;

  modport slave (
    input  mem_valid_i, stall_i, mem_pc_i, mem_in_delayslot_i, mem_bad_addr_i,
           adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_i,
           eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, redirect_o, newpc_o, busy_o
  );

  modport master (
    output mem_valid_i, stall_i, mem_pc_i, mem_in_delayslot_i, mem_bad_addr_i,
           adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_i,
           eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, redirect_o, newpc_o, busy_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception sequencer: CP0 update + redirect pulse one cycle after acceptance, then
// flush held FLUSH_CYCLES cycles; stall_i or a busy FSM defers acceptance, inputs ignored while flushing.
module exc_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input logic clk,
  input logic rst,
  exc_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [0:0]  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] excepttype_q, excepttype_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        delayslot_q, delayslot_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        flush_q, flush_d;
  logic        redirect_q, redirect_d;
  logic [31:0] newpc_q, newpc_d;

  logic        int_pend, any_flag, accept;
  logic [31:0] code_sel, bad_sel;
  logic        unused_ok;

  assign unused_ok = ^{bus.cp0_status_i[31:16], bus.cp0_status_i[7:2],
                       bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0]};

  always_comb begin
    int_pend = (|(bus.cp0_cause_i[15:8] & bus.cp0_status_i[15:8]))
               & bus.cp0_status_i[0] & ~bus.cp0_status_i[1];
    any_flag = bus.adel_if_i | bus.ri_i | bus.ov_i | bus.trap_i | bus.syscall_i
               | bus.break_i | bus.adel_ld_i | bus.ades_i | bus.eret_i;
    accept   = (state_q == IDLE) & bus.mem_valid_i & ~bus.stall_i & (int_pend | any_flag);

    code_sel = 32'h0;
    bad_sel  = 32'h0;
    if (int_pend)            code_sel = 32'h1;
    else if (bus.adel_if_i) begin
      code_sel = 32'h4;
      bad_sel  = bus.mem_pc_i;
    end
    else if (bus.ri_i)       code_sel = 32'hA;
    else if (bus.ov_i)       code_sel = 32'hC;
    else if (bus.trap_i)     code_sel = 32'hD;
    else if (bus.syscall_i)  code_sel = 32'h8;
    else if (bus.break_i)    code_sel = 32'h9;
    else if (bus.adel_ld_i) begin
      code_sel = 32'h4;
      bad_sel  = bus.mem_bad_addr_i;
    end
    else if (bus.ades_i) begin
      code_sel = 32'h5;
      bad_sel  = bus.mem_bad_addr_i;
    end
    else if (bus.eret_i)     code_sel = 32'hE;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    excepttype_d = 32'h0;
    inst_addr_d  = 32'h0;
    delayslot_d  = 1'b0;
    bad_addr_d   = 32'h0;
    flush_d      = 1'b0;
    redirect_d   = 1'b0;
    newpc_d      = 32'h0;
    if (accept) begin
      state_d      = FLUSH;
      cnt_d        = CW'(FLUSH_CYCLES - 1);
      excepttype_d = code_sel;
      inst_addr_d  = bus.mem_pc_i;
      delayslot_d  = bus.mem_in_delayslot_i;
      bad_addr_d   = bad_sel;
      flush_d      = 1'b1;
      redirect_d   = 1'b1;
      newpc_d      = (code_sel == 32'hE) ? bus.cp0_epc_i : EXC_VECTOR;
    end else if (state_q == FLUSH) begin
      // cnt_q counts the flush cycles still to come after the current one
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q - CW'(1);
        flush_d = 1'b1;
        newpc_d = newpc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      excepttype_q <= 32'h0;
      inst_addr_q  <= 32'h0;
      delayslot_q  <= 1'b0;
      bad_addr_q   <= 32'h0;
      flush_q      <= 1'b0;
      redirect_q   <= 1'b0;
      newpc_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      excepttype_q <= excepttype_d;
      inst_addr_q  <= inst_addr_d;
      delayslot_q  <= delayslot_d;
      bad_addr_q   <= bad_addr_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      newpc_q      <= newpc_d;
    end
  end

  assign bus.excepttype_o        = excepttype_q;
  assign bus.current_inst_addr_o = inst_addr_q;
  assign bus.is_in_delayslot_o   = delayslot_q;
  assign bus.bad_addr_o          = bad_addr_q;
  assign bus.flush_o             = flush_q;
  assign bus.redirect_o          = redirect_q;
  assign bus.newpc_o             = newpc_q;
  assign bus.busy_o              = (state_q == FLUSH);
endmodule
